pix_stream_tx: RTL and testbench
================================

PIX_STREAM_TX -- requirements
Module: pix_stream_tx

Interface
REQ-001 The block SHALL have parameters:
- LINE_W, default 1024, pixels per image row.
- FRAME_PIX, default 1048576 (2**20), pixels per frame.
REQ-002 The block SHALL have ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- s_axi_data  in  32  packed pixel word; byte0 = [7:0] is the earliest pixel.
- s_axi_keep  in  4  byte-valid mask; bit i qualifies byte i.
- s_axi_last  in  1  final word of the DMA frame.
- s_axi_valid  in  1  word valid.
- s_axi_ready  out  1  word accepted when valid&&ready.
- axi_data_out  out  8  gray pixel to filter.
- axi_keep  out  4  constant 4'b0001 while axi_valid=1, else 0.
- axi_last  out  1  last pixel of a row.
- axi_valid  out  1  pixel valid.
- gauss_axi_ready  in  1  filter ready; pixel transfers when axi_valid&&gauss_axi_ready.
- frame_done  out  1  one-cycle pulse, frame completed.
- frame_err  out  1  one-cycle pulse, frame length mismatch.

Function
REQ-003 The block SHALL hold one 32-bit word, its 4-bit pending-byte mask and its last flag in a holding register.
REQ-004 Pending bytes SHALL be emitted lowest index first, one per transfer; bytes with keep=0 SHALL be skipped with no cycle lost.
REQ-005 s_axi_ready SHALL be 1 when the holding register is empty, or when the current transfer consumes its final pending byte (a 0-bubble word handover).
REQ-006 A word accepted at edge N SHALL present its first kept byte on axi_data_out with axi_valid=1 from cycle N+1.
REQ-007 A word with s_axi_keep=4'b0000 SHALL be accepted and discarded; it SHALL produce no output beat.
REQ-008 While axi_valid=1 and gauss_axi_ready=0, axi_data_out, axi_last and axi_keep SHALL hold stable.
REQ-009 axi_valid SHALL NOT deassert until its transfer completes.
REQ-010 Sustained throughput SHALL be 1 pixel/cycle when the upstream is always valid, keep=4'hF and gauss_axi_ready=1.
REQ-011 Column counter col (0..LINE_W-1) SHALL increment on each transfer and wrap to 0 after LINE_W-1.
REQ-012 axi_last SHALL be 1 exactly on the beat with col==LINE_W-1.
REQ-013 Pixel counter pix (0..FRAME_PIX-1) SHALL increment on each transfer.
REQ-014 On the transfer with pix==FRAME_PIX-1, pix and col SHALL return to 0, and frame_done SHALL pulse in the following cycle.
REQ-015 Short frame: when the last pending byte of a word with last flag=1 transfers and pix!=FRAME_PIX-1:
- frame_err SHALL pulse in the following cycle;
- pix and col SHALL clear to 0;
- frame_done SHALL NOT pulse.
REQ-016 Long frame: when pix reaches FRAME_PIX-1 on a byte whose word has last flag=0:
- frame_done and frame_err SHALL both pulse;
- counting SHALL continue from 0 with the remaining bytes.
REQ-017 A last-flagged word with keep=0 SHALL be evaluated as a REQ-015 event at the cycle it is accepted.
REQ-018 When frame completion and a new word acceptance occur in the same cycle, both SHALL take effect.
REQ-019 The block SHALL generate no backpressure-dependent combinational path from gauss_axi_ready to axi_valid.
REQ-020 s_axi_ready MAY depend combinationally on gauss_axi_ready.

Reset
REQ-021 While rst_n=0, all of the following SHALL be 0: holding register, mask, col, pix, axi_valid, axi_last, axi_keep, axi_data_out, frame_done, frame_err.
REQ-022 While rst_n=0, s_axi_ready SHALL be 0.
REQ-023 s_axi_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-024 Reset mid-frame SHALL discard any partially emitted word; the first word after reset starts at col=0, pix=0.

Verification
REQ-025 Words 0x04030201, 0x08070605 with keep=F and gauss_axi_ready=1 -> pixels 01..08 on 8 consecutive cycles, first at acceptance+1, axi_keep=0001.
REQ-026 keep=4'b1010 on 0xDDCCBBAA, then keep=0 word -> exactly two beats BB, DD; the keep=0 word is accepted in one cycle with no beat.
REQ-027 gauss_axi_ready toggled 1,0,0,1 during a word -> data and valid held through the stall; no pixel dropped or duplicated.
REQ-028 LINE_W=8, FRAME_PIX=32, 8 full words, last on the 8th -> axi_last on beats 8, 16, 24, 32; frame_done one pulse after beat 32; frame_err=0.
REQ-029 Same parameters, last on the 5th word -> frame_err pulse after beat 20; the next frame's first beat has col=0, and axi_last appears on its 8th beat.
REQ-030 rst_n pulsed low after 3 beats of a word -> all outputs 0 during reset; after release the next word's byte0 is emitted as col 0.

Source files
------------

// File: rtl/pix_stream_tx.sv
// Unpacks 32-bit DMA words into a stream of 8-bit gray pixels for the filter,
// tracking row/frame position and flagging frames whose length does not match.
module pix_stream_tx #(
  parameter int LINE_W    = 1024,
  parameter int FRAME_PIX = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axi_data,
  input  logic [3:0]  s_axi_keep,
  input  logic        s_axi_last,
  input  logic        s_axi_valid,
  output logic        s_axi_ready,
  output logic [7:0]  axi_data_out,
  output logic [3:0]  axi_keep,
  output logic        axi_last,
  output logic        axi_valid,
  input  logic        gauss_axi_ready,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int PIX_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(LINE_W - 1);
  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(FRAME_PIX - 1);

  logic [31:0]      holdData_q, holdData_d;
  logic [3:0]       holdMask_q, holdMask_d;
  logic             holdLast_q, holdLast_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [3:0] selOneHot;
  logic [7:0] selByte;
  logic [3:0] remainMask;
  logic       beatFire;
  logic       finalByte;
  logic       wordAccept;
  logic       emptyLast;

  // Lowest pending byte is always the one on the output; skipped bytes never cost a cycle.
  always_comb begin
    selOneHot = 4'b0000;
    selByte   = holdData_q[7:0];
    if (holdMask_q[0]) begin
      selOneHot = 4'b0001;
      selByte   = holdData_q[7:0];
    end else if (holdMask_q[1]) begin
      selOneHot = 4'b0010;
      selByte   = holdData_q[15:8];
    end else if (holdMask_q[2]) begin
      selOneHot = 4'b0100;
      selByte   = holdData_q[23:16];
    end else if (holdMask_q[3]) begin
      selOneHot = 4'b1000;
      selByte   = holdData_q[31:24];
    end
  end

  assign axi_valid    = |holdMask_q;
  assign axi_keep     = {3'b000, axi_valid};
  assign axi_data_out = axi_valid ? selByte : 8'h00;
  assign axi_last     = axi_valid && (col_q == COL_MAX);
  assign frame_done   = done_q;
  assign frame_err    = err_q;

  assign remainMask  = holdMask_q & ~selOneHot;
  assign beatFire    = axi_valid && gauss_axi_ready;
  assign finalByte   = beatFire && (remainMask == 4'b0000);
  assign s_axi_ready = rst_n && ((holdMask_q == 4'b0000) || finalByte);
  assign wordAccept  = s_axi_valid && s_axi_ready;
  assign emptyLast   = wordAccept && (s_axi_keep == 4'b0000) && s_axi_last;

  // Frame bookkeeping: a full count always completes the frame; a last-flagged word
  // ending early, or a count wrapping before the last flag, is reported as an error.
  always_comb begin
    holdData_d = holdData_q;
    holdMask_d = holdMask_q;
    holdLast_d = holdLast_q;
    col_d      = col_q;
    pix_d      = pix_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (beatFire) begin
      holdMask_d = remainMask;
      if (pix_q == PIX_MAX) begin
        pix_d  = '0;
        col_d  = '0;
        done_d = 1'b1;
        if (!(holdLast_q && finalByte)) begin
          err_d = 1'b1;
        end
      end else if (holdLast_q && finalByte) begin
        pix_d = '0;
        col_d = '0;
        err_d = 1'b1;
      end else begin
        pix_d = pix_q + PIX_W'(1);
        col_d = (col_q == COL_MAX) ? '0 : col_q + COL_W'(1);
      end
    end

    if (wordAccept) begin
      holdData_d = s_axi_data;
      holdMask_d = s_axi_keep;
      holdLast_d = s_axi_last;
    end

    if (emptyLast) begin
      pix_d = '0;
      col_d = '0;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdData_q <= '0;
      holdMask_q <= '0;
      holdLast_q <= 1'b0;
      col_q      <= '0;
      pix_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      holdData_q <= holdData_d;
      holdMask_q <= holdMask_d;
      holdLast_q <= holdLast_d;
      col_q      <= col_d;
      pix_q      <= pix_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_pix_stream_tx.sv
// Directed bench for pix_stream_tx with an 8-pixel row and 32-pixel frame.
module tb_pix_stream_tx;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_axi_data;
  logic [3:0]  s_axi_keep;
  logic        s_axi_last;
  logic        s_axi_valid;
  logic        s_axi_ready;
  logic [7:0]  axi_data_out;
  logic [3:0]  axi_keep;
  logic        axi_last;
  logic        axi_valid;
  logic        gauss_axi_ready;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0] beatData[$];
  logic       beatLast[$];
  logic [3:0] beatKeep[$];
  int         beatCyc[$];
  int         accCyc[$];
  int         doneCyc[$];
  int         errCyc[$];

  pix_stream_tx #(.LINE_W(8), .FRAME_PIX(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axi_data(s_axi_data),
    .s_axi_keep(s_axi_keep),
    .s_axi_last(s_axi_last),
    .s_axi_valid(s_axi_valid),
    .s_axi_ready(s_axi_ready),
    .axi_data_out(axi_data_out),
    .axi_keep(axi_keep),
    .axi_last(axi_last),
    .axi_valid(axi_valid),
    .gauss_axi_ready(gauss_axi_ready),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after rising edges, so the falling edge sees a settled cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi_valid && gauss_axi_ready) begin
        beatData.push_back(axi_data_out);
        beatLast.push_back(axi_last);
        beatKeep.push_back(axi_keep);
        beatCyc.push_back(cyc);
      end
      if (s_axi_valid && s_axi_ready) accCyc.push_back(cyc);
      if (frame_done) doneCyc.push_back(cyc);
      if (frame_err) errCyc.push_back(cyc);
    end
  end

  task automatic clearLogs();
    beatData.delete();
    beatLast.delete();
    beatKeep.delete();
    beatCyc.delete();
    accCyc.delete();
    doneCyc.delete();
    errCyc.delete();
  endtask

  task automatic doReset();
    rst_n           = 1'b0;
    s_axi_valid     = 1'b0;
    s_axi_data      = 32'h0;
    s_axi_keep      = 4'h0;
    s_axi_last      = 1'b0;
    gauss_axi_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearLogs();
  endtask

  task automatic sendWord(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit got;
    got         = 1'b0;
    s_axi_data  = d;
    s_axi_keep  = k;
    s_axi_last  = l;
    s_axi_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_axi_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (!got) $display("[TB] FAIL word_accept: word %h not accepted, ready=%b required 1", d, s_axi_ready);
    else passed++;
  endtask

  task automatic idle(input int n);
    s_axi_valid = 1'b0;
    s_axi_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    s_axi_valid     = 1'b1;
    s_axi_data      = 32'hFFFF_FFFF;
    s_axi_keep      = 4'hF;
    s_axi_last      = 1'b1;
    gauss_axi_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (axi_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", axi_valid); else passed++;
    checks++; if (axi_data_out !== 8'h00) $display("[TB] FAIL rst_data: got %h want 00", axi_data_out); else passed++;
    checks++; if (axi_keep !== 4'h0) $display("[TB] FAIL rst_keep: got %h want 0", axi_keep); else passed++;
    checks++; if (axi_last !== 1'b0) $display("[TB] FAIL rst_last: got %b want 0", axi_last); else passed++;
    checks++; if (frame_done !== 1'b0) $display("[TB] FAIL rst_done: got %b want 0", frame_done); else passed++;
    checks++; if (frame_err !== 1'b0) $display("[TB] FAIL rst_err: got %b want 0", frame_err); else passed++;
    checks++; if (s_axi_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b want 0", s_axi_ready); else passed++;
    s_axi_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (s_axi_ready !== 1'b1) $display("[TB] FAIL ready_after_rst: got %b want 1", s_axi_ready); else passed++;
    clearLogs();
  endtask

  task automatic test_basic();
    int bad;
    doReset();
    sendWord(32'h0403_0201, 4'hF, 1'b0);
    sendWord(32'h0807_0605, 4'hF, 1'b0);
    idle(6);
    checks++; if (beatData.size() !== 8) $display("[TB] FAIL basic_count: got %0d want 8", beatData.size()); else passed++;
    if (beatData.size() == 8 && accCyc.size() >= 1) begin
      bad = 0;
      for (int i = 0; i < 8; i++) if (beatData[i] !== 8'(i + 1)) bad++;
      checks++; if (bad !== 0) $display("[TB] FAIL basic_data: %0d wrong bytes want 0", bad); else passed++;
      bad = 0;
      for (int i = 0; i < 8; i++) if (beatCyc[i] !== beatCyc[0] + i) bad++;
      checks++; if (bad !== 0) $display("[TB] FAIL basic_throughput: %0d gaps want 0", bad); else passed++;
      checks++; if (beatCyc[0] !== accCyc[0] + 1) $display("[TB] FAIL basic_latency: first beat %0d want %0d", beatCyc[0], accCyc[0] + 1); else passed++;
      bad = 0;
      for (int i = 0; i < 8; i++) if (beatKeep[i] !== 4'b0001) bad++;
      checks++; if (bad !== 0) $display("[TB] FAIL basic_keep: %0d beats bad keep want 0", bad); else passed++;
      bad = 0;
      for (int i = 0; i < 7; i++) if (beatLast[i] !== 1'b0) bad++;
      checks++; if (bad !== 0 || beatLast[7] !== 1'b1) $display("[TB] FAIL basic_last: early=%0d last7=%b want 0/1", bad, beatLast[7]); else passed++;
    end
  endtask

  task automatic test_keep();
    doReset();
    sendWord(32'hDDCC_BBAA, 4'b1010, 1'b0);
    sendWord(32'h1122_3344, 4'b0000, 1'b0);
    idle(5);
    checks++; if (beatData.size() !== 2) $display("[TB] FAIL keep_count: got %0d want 2", beatData.size()); else passed++;
    if (beatData.size() == 2 && accCyc.size() == 2) begin
      checks++; if (beatData[0] !== 8'hBB) $display("[TB] FAIL keep_b0: got %h want BB", beatData[0]); else passed++;
      checks++; if (beatData[1] !== 8'hDD) $display("[TB] FAIL keep_b1: got %h want DD", beatData[1]); else passed++;
      checks++; if (beatCyc[1] !== beatCyc[0] + 1) $display("[TB] FAIL keep_skip: gap %0d want 1", beatCyc[1] - beatCyc[0]); else passed++;
      checks++; if (accCyc[1] !== accCyc[0] + 2) $display("[TB] FAIL keep_zero_accept: at %0d want %0d", accCyc[1], accCyc[0] + 2); else passed++;
    end
    checks++; if (s_axi_ready !== 1'b1) $display("[TB] FAIL keep_ready_idle: got %b want 1", s_axi_ready); else passed++;
  endtask

  task automatic test_stall();
    logic pattern [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] expect_b [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int bad;
    doReset();
    sendWord(32'hA4A3_A2A1, 4'hF, 1'b0);
    s_axi_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      gauss_axi_ready = pattern[i];
      @(negedge clk);
      if (pattern[i] == 1'b0) begin
        checks++; if (axi_valid !== 1'b1) $display("[TB] FAIL stall_valid: got %b want 1", axi_valid); else passed++;
        checks++; if (axi_data_out !== 8'hA2) $display("[TB] FAIL stall_data: got %h want A2", axi_data_out); else passed++;
      end
      @(posedge clk);
      #1;
    end
    gauss_axi_ready = 1'b1;
    idle(3);
    checks++; if (beatData.size() !== 4) $display("[TB] FAIL stall_count: got %0d want 4", beatData.size()); else passed++;
    if (beatData.size() == 4) begin
      bad = 0;
      for (int i = 0; i < 4; i++) if (beatData[i] !== expect_b[i]) bad++;
      checks++; if (bad !== 0) $display("[TB] FAIL stall_order: %0d wrong want 0", bad); else passed++;
    end
  endtask

  task automatic test_frame();
    int bad;
    int nLast;
    doReset();
    for (int w = 0; w < 8; w++)
      sendWord({8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)}, 4'hF, w == 7);
    idle(6);
    checks++; if (beatData.size() !== 32) $display("[TB] FAIL frame_count: got %0d want 32", beatData.size()); else passed++;
    if (beatData.size() == 32) begin
      bad = 0; nLast = 0;
      for (int i = 0; i < 32; i++) begin
        if (beatData[i] !== 8'(i + 1)) bad++;
        if (beatLast[i] === 1'b1) nLast++;
      end
      checks++; if (bad !== 0) $display("[TB] FAIL frame_data: %0d wrong want 0", bad); else passed++;
      checks++; if (nLast !== 4) $display("[TB] FAIL frame_last_count: got %0d want 4", nLast); else passed++;
      checks++; if (beatLast[7] !== 1'b1 || beatLast[15] !== 1'b1 || beatLast[23] !== 1'b1 || beatLast[31] !== 1'b1)
        $display("[TB] FAIL frame_last_pos: got %b%b%b%b want 1111", beatLast[7], beatLast[15], beatLast[23], beatLast[31]);
      else passed++;
      checks++; if (doneCyc.size() !== 1) $display("[TB] FAIL frame_done_count: got %0d want 1", doneCyc.size()); else passed++;
      if (doneCyc.size() == 1) begin
        checks++; if (doneCyc[0] !== beatCyc[31] + 1) $display("[TB] FAIL frame_done_time: got %0d want %0d", doneCyc[0], beatCyc[31] + 1); else passed++;
      end
      checks++; if (errCyc.size() !== 0) $display("[TB] FAIL frame_err_count: got %0d want 0", errCyc.size()); else passed++;
    end
  endtask

  task automatic test_short();
    int bad;
    doReset();
    for (int w = 0; w < 5; w++)
      sendWord({8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)}, 4'hF, w == 4);
    for (int w = 0; w < 2; w++)
      sendWord({8'(4*w+8'h44), 8'(4*w+8'h43), 8'(4*w+8'h42), 8'(4*w+8'h41)}, 4'hF, 1'b0);
    idle(6);
    checks++; if (beatData.size() !== 28) $display("[TB] FAIL short_count: got %0d want 28", beatData.size()); else passed++;
    checks++; if (errCyc.size() !== 1) $display("[TB] FAIL short_err_count: got %0d want 1", errCyc.size()); else passed++;
    checks++; if (doneCyc.size() !== 0) $display("[TB] FAIL short_done_count: got %0d want 0", doneCyc.size()); else passed++;
    if (beatData.size() == 28 && errCyc.size() == 1) begin
      checks++; if (errCyc[0] !== beatCyc[19] + 1) $display("[TB] FAIL short_err_time: got %0d want %0d", errCyc[0], beatCyc[19] + 1); else passed++;
      checks++; if (beatLast[7] !== 1'b1 || beatLast[15] !== 1'b1 || beatLast[19] !== 1'b0)
        $display("[TB] FAIL short_last_first: got %b%b%b want 110", beatLast[7], beatLast[15], beatLast[19]);
      else passed++;
      checks++; if (beatData[20] !== 8'h41) $display("[TB] FAIL short_next_data: got %h want 41", beatData[20]); else passed++;
      bad = 0;
      for (int i = 20; i < 27; i++) if (beatLast[i] !== 1'b0) bad++;
      checks++; if (bad !== 0 || beatLast[27] !== 1'b1) $display("[TB] FAIL short_next_last: early=%0d last27=%b want 0/1", bad, beatLast[27]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    doReset();
    sendWord(32'h4433_2211, 4'hF, 1'b0);
    s_axi_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++; if (beatData.size() !== 3) $display("[TB] FAIL mid_pre_beats: got %0d want 3", beatData.size()); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (axi_valid !== 1'b0 || axi_data_out !== 8'h00 || axi_keep !== 4'h0 || axi_last !== 1'b0)
      $display("[TB] FAIL mid_rst_out: valid=%b data=%h keep=%h last=%b want 0", axi_valid, axi_data_out, axi_keep, axi_last);
    else passed++;
    checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0 || s_axi_ready !== 1'b0)
      $display("[TB] FAIL mid_rst_flags: done=%b err=%b ready=%b want 0", frame_done, frame_err, s_axi_ready);
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearLogs();
    sendWord(32'h5857_5655, 4'hF, 1'b0);
    sendWord(32'h5C5B_5A59, 4'hF, 1'b0);
    idle(6);
    checks++; if (beatData.size() !== 8) $display("[TB] FAIL mid_post_count: got %0d want 8", beatData.size()); else passed++;
    if (beatData.size() == 8) begin
      checks++; if (beatData[0] !== 8'h55) $display("[TB] FAIL mid_post_first: got %h want 55", beatData[0]); else passed++;
      bad = 0;
      for (int i = 0; i < 7; i++) if (beatLast[i] !== 1'b0) bad++;
      checks++; if (bad !== 0 || beatLast[7] !== 1'b1) $display("[TB] FAIL mid_post_col: early=%0d last7=%b want 0/1", bad, beatLast[7]); else passed++;
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    s_axi_valid     = 1'b0;
    s_axi_data      = 32'h0;
    s_axi_keep      = 4'h0;
    s_axi_last      = 1'b0;
    gauss_axi_ready = 1'b1;
    test_reset();
    test_basic();
    test_keep();
    test_stall();
    test_frame();
    test_short();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
